// File: rtl/pps_stamp_packer_pkg.sv
// pps_stamp_packer_pkg: shared event-entry layout, beat layout and FSM state constants.
// No ports. Entry layout (113 bits): {seq[15:0], first, short, long, stamp[93:0]}.
package pps_stamp_packer_pkg;

    localparam int SEQ_W      = 16;
    localparam int STAMP_W    = 94;
    localparam int FLAG_W     = 3;
    localparam int ENTRY_W    = STAMP_W + SEQ_W + FLAG_W;
    localparam int FLAG_FIRST = 2;
    localparam int FLAG_SHORT = 1;
    localparam int FLAG_LONG  = 0;
    localparam int BEAT_CNT   = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_B0   = 3'd1;
    localparam logic [2:0] S_B1   = 3'd2;
    localparam logic [2:0] S_B2   = 3'd3;
    localparam logic [2:0] S_B3   = 3'd4;

    // Beat idx of BEAT_CNT for one buffered event.
    function automatic logic [31:0] beat_word(input logic [ENTRY_W-1:0] e, input logic [1:0] idx);
        return idx == 2'd0 ? {e[ENTRY_W-1 -: SEQ_W], 13'b0, e[STAMP_W +: FLAG_W]} :
               idx == 2'd1 ? {2'b0, e[93:64]} :
               idx == 2'd2 ? e[63:32] : e[31:0];
    endfunction

endpackage

// File: rtl/pps_stamp_packer_evt.sv
// pps_evt_fifo: synchronous event FIFO with first-word-fall-through read data.
// Ports: clk, rstn (sync, active-low), push/wdata, pop/rdata, full, empty.
// Push while full and pop while empty are ignored.
module pps_evt_fifo #(
    parameter int WIDTH = 113,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wp[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + 1'b1;
            if (pop && !empty)
                rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/pps_stamp_packer.sv
// pps_stamp_packer: timestamps PPS edges, measures period, buffers events and emits 4-beat AXIS packets.
// Ports: clk, rstn (sync, active-low), pps, stamp_in[93:0] (latched timestamp),
//        m_axis_tdata/tvalid/tready/tlast (packet stream), overflow_cnt (dropped events, saturating),
//        last_period (most recent measured period), missing_pps (period counter past MAX_PERIOD).
module pps_stamp_packer
    import pps_stamp_packer_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MIN_PERIOD = 32'd124_999_000,
    parameter logic [31:0] MAX_PERIOD = 32'd125_001_000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         pps,
    input  logic [93:0]  stamp_in,
    output logic [31:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [15:0]  overflow_cnt,
    output logic [31:0]  last_period,
    output logic         missing_pps
);

    logic                      pps_d;
    logic                      pps_edge;
    logic                      seen;
    logic                      cap_pend;
    logic [SEQ_W+FLAG_W-1:0]   pend_meta;
    logic [31:0]               cnt;
    logic [31:0]               period;
    logic [SEQ_W-1:0]          seq;
    logic                      short_f;
    logic                      long_f;
    logic [ENTRY_W-1:0]        fifo_rd;
    logic [ENTRY_W-1:0]        entry;
    logic                      full;
    logic                      empty;
    logic                      load;
    logic                      hs;
    logic [2:0]                state;
    logic [2:0]                nxt;

    assign pps_edge = pps & ~pps_d;
    // Saturating counter+1 doubles as the measured period and the counter's next value.
    assign period   = &cnt ? cnt : cnt + 32'd1;
    assign short_f  = seen & (period < MIN_PERIOD);
    assign long_f   = seen & (period > MAX_PERIOD);
    assign missing_pps = seen & (cnt >= MAX_PERIOD) & ~pps_edge;

    assign hs   = m_axis_tvalid & m_axis_tready;
    // Pop on entering B0: from IDLE, or straight after a completed B3 so packets run back-to-back.
    assign load = ~empty & ((state == S_IDLE) | ((state == S_B3) & hs));
    assign nxt  = load ? S_B0 : hs ? (state == S_B3 ? S_IDLE : state + 3'd1) : state;

    assign m_axis_tvalid = state != S_IDLE;
    assign m_axis_tlast  = state == S_B3;
    assign m_axis_tdata  = beat_word(entry, 2'(state - 3'd1));

    // Event metadata is frozen in the edge cycle; the stamp itself is only valid one cycle later.
    pps_evt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cap_pend),
        .wdata ({pend_meta, stamp_in}),
        .pop   (load),
        .rdata (fifo_rd),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pps_d        <= 1'b0;
            seen         <= 1'b0;
            cap_pend     <= 1'b0;
            pend_meta    <= '0;
            cnt          <= '0;
            seq          <= '0;
            last_period  <= '0;
            overflow_cnt <= '0;
            state        <= S_IDLE;
            entry        <= '0;
        end else begin
            pps_d    <= pps;
            cap_pend <= pps_edge;
            cnt      <= pps_edge ? 32'd0 : period;
            if (pps_edge) begin
                pend_meta <= {seq, ~seen, short_f, long_f};
                seq       <= seq + 16'd1;
                seen      <= 1'b1;
                if (seen)
                    last_period <= period;
            end
            // Full is judged before any same-cycle pop.
            if (cap_pend && full && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 16'd1;
            state <= nxt;
            if (load)
                entry <= fifo_rd;
        end
    end

endmodule
